// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bundle for the FFT output reorder buffer.
// in_sop exists only when FFT_REORDER_SOP_EN is defined.
interface fft_bitrev_reorder_if #(
  parameter int width = 16,
  parameter int log2n = 3
);
  logic             in_valid;
  logic [width-1:0] in_re;
  logic [width-1:0] in_im;
`ifdef FFT_REORDER_SOP_EN
  logic             in_sop;
`endif
  logic             out_valid;
  logic [width-1:0] out_re;
  logic [width-1:0] out_im;
  logic             out_last;
  logic [log2n-1:0] out_idx;

  modport master (
    output in_valid, in_re, in_im,
`ifdef FFT_REORDER_SOP_EN
    in_sop,
`endif
    input  out_valid, out_re, out_im,
    out_last, out_idx
  );

  modport slave (
    input  in_valid, in_re, in_im,
`ifdef FFT_REORDER_SOP_EN
    in_sop,
`endif
    output out_valid, out_re, out_im,
    out_last, out_idx
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT frames in, natural order out.
// Optional FFT_REORDER_SOP_EN adds in_sop to resynchronise framing.
module fft_bitrev_reorder #(
  parameter int width = 16,
  parameter int log2n = 3
) (
  input logic clk,
  input logic rst,
  fft_bitrev_reorder_if.slave io
);
  localparam int n = 1 << log2n;

  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [log2n-1:0] bitrev(
    input logic [log2n-1:0] a
  );
    logic [log2n-1:0] r;
    for (int k = 0; k < log2n; k++)
      r[log2n-1-k] = a[k];
    return r;
  endfunction

  logic [2*width-1:0] mem [2*n];

  logic [log2n-1:0] wr_cnt;
  logic             wr_bank;
  logic [log2n-1:0] wr_addr;
  logic             wr_done;
  logic             sop;
  logic [1:0]       full;
  logic [1:0]       full_nx;
  logic [1:0]       set_full;
  logic [1:0]       avail;
  logic [1:0]       clr;

  state_t           state, state_nx;
  logic [log2n-1:0] rd_cnt, rd_cnt_nx;
  logic             rd_bank, rd_bank_nx;
  logic             rd_en;

  logic             out_valid;
  logic [width-1:0] out_re;
  logic [width-1:0] out_im;
  logic             out_last;
  logic [log2n-1:0] out_idx;

`ifdef FFT_REORDER_SOP_EN
  assign sop = io.in_valid & io.in_sop;
`else
  assign sop = 1'b0;
`endif

  assign wr_addr  = sop ? '0 : bitrev(wr_cnt);
  assign wr_done  = io.in_valid && !sop
                 && (wr_cnt == '1);
  assign set_full = wr_done ? (2'b01 << wr_bank)
                            : 2'b00;
  // A bank completing this cycle may be chained onto directly.
  assign avail    = full | set_full;

  always_ff @(posedge clk) begin
    if (io.in_valid)
      mem[{wr_bank, wr_addr}] <= {io.in_re, io.in_im};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (io.in_valid) begin
      if (sop)
        wr_cnt <= log2n'(1);
      else
        wr_cnt <= wr_cnt + 1'b1;
      if (wr_done)
        wr_bank <= ~wr_bank;
    end
  end

  always_comb begin
    state_nx   = state;
    rd_cnt_nx  = rd_cnt;
    rd_bank_nx = rd_bank;
    clr        = 2'b00;
    rd_en      = 1'b0;
    case (state)
      IDLE: begin
        if (|full) begin
          state_nx   = READ;
          rd_bank_nx = ~full[0];
          rd_cnt_nx  = '0;
          clr        = 2'b01 << rd_bank_nx;
        end
      end
      READ: begin
        rd_en     = 1'b1;
        rd_cnt_nx = rd_cnt + 1'b1;
        if (rd_cnt == '1) begin
          if (avail[~rd_bank]) begin
            rd_bank_nx = ~rd_bank;
            clr        = 2'b01 << rd_bank_nx;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    full_nx = avail & ~clr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_cnt    <= '0;
      rd_bank   <= 1'b0;
      full      <= 2'b00;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_last  <= 1'b0;
      out_idx   <= '0;
    end else begin
      state     <= state_nx;
      rd_cnt    <= rd_cnt_nx;
      rd_bank   <= rd_bank_nx;
      full      <= full_nx;
      out_valid <= rd_en;
      out_last  <= rd_en && (rd_cnt == '1);
      if (rd_en) begin
        {out_re, out_im} <= mem[{rd_bank, rd_cnt}];
        out_idx          <= rd_cnt;
      end
    end
  end

  assign io.out_valid = out_valid;
  assign io.out_re    = out_re;
  assign io.out_im    = out_im;
  assign io.out_last  = out_last;
  assign io.out_idx   = out_idx;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder, N=8.
// Expected samples carry the cycle they must appear in.
module tb_fft_bitrev_reorder;
  localparam int W = 16;
  localparam int L = 3;
  localparam int br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [2:0]  idx;
    logic        last;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_bitrev_reorder_if #(.width(W), .log2n(L)) bus ();

  fft_bitrev_reorder #(.width(W), .log2n(L)) dut (
    .clk(clk),
    .rst(rst),
    .io(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame whose natural-order sample i is
  // re=base+i, im=FFFF-base-i, in bit-reversed order.
  task automatic send(input int base, input bit gap,
                      input bit sop);
    int c;
    for (int j = 0; j < 8; j++) begin
      bus.in_valid = 1'b1;
      bus.in_re    = 16'(base + br[j]);
      bus.in_im    = 16'(16'hFFFF - base - br[j]);
`ifdef FFT_REORDER_SOP_EN
      bus.in_sop   = sop && (j == 0);
`endif
      c = cyc;
      tick();
      if (gap && j < 7) begin
        bus.in_valid = 1'b0;
        tick();
      end
    end
    bus.in_valid = 1'b0;
`ifdef FFT_REORDER_SOP_EN
    bus.in_sop = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      q.push_back('{re: 16'(base + i),
                    im: 16'(16'hFFFF - base - i),
                    idx: 3'(i), last: (i == 7),
                    cyc: c + 3 + i});
    end
    if (sop) checks = checks + 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    q.delete();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_re !== 16'h0 ||
        bus.out_im !== 16'h0 || bus.out_last !== 1'b0 ||
        bus.out_idx !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%b re=%h im=%h last=%b idx=%0d, want all 0",
               bus.out_valid, bus.out_re, bus.out_im,
               bus.out_last, bus.out_idx);
    end
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_re !== e.re ||
          bus.out_im !== e.im || bus.out_idx !== e.idx ||
          bus.out_last !== e.last) begin
        failures++;
        $display("FAIL sample@%0d: got v=%b re=%h im=%h idx=%0d last=%b, want v=1 re=%h im=%h idx=%0d last=%b",
                 cyc, bus.out_valid, bus.out_re, bus.out_im,
                 bus.out_idx, bus.out_last, e.re, e.im,
                 e.idx, e.last);
      end
    end else if (bus.out_valid === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL unexpected@%0d: got valid re=%h idx=%0d, want no output",
               cyc, bus.out_re, bus.out_idx);
    end
  end

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_re    = '0;
    bus.in_im    = '0;
`ifdef FFT_REORDER_SOP_EN
    bus.in_sop   = 1'b0;
`endif
    tick();
    do_reset();
    tick();

    send(0, 1'b0, 1'b0);
    repeat (12) tick();

    send(16'h100, 1'b0, 1'b0);
    send(16'h200, 1'b0, 1'b0);
    send(16'h300, 1'b0, 1'b0);
    repeat (12) tick();

    send(16'h400, 1'b1, 1'b0);
    repeat (12) tick();

    for (int j = 0; j < 5; j++) begin
      bus.in_valid = 1'b1;
      bus.in_re    = 16'hDEAD;
      bus.in_im    = 16'hBEEF;
      tick();
    end
    bus.in_valid = 1'b0;
    do_reset();
    send(16'h500, 1'b0, 1'b0);
    repeat (12) tick();

    send(16'h600, 1'b0, 1'b0);
    repeat (5) tick();
    do_reset();
    send(16'h700, 1'b0, 1'b0);
    repeat (12) tick();

`ifdef FFT_REORDER_SOP_EN
    for (int j = 0; j < 3; j++) begin
      bus.in_valid = 1'b1;
      bus.in_re    = 16'hDEAD;
      bus.in_im    = 16'hBEEF;
      tick();
    end
    send(16'h800, 1'b0, 1'b1);
    repeat (12) tick();
`endif

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected samples never seen, want 0",
               q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Output reorder buffer for the radix-2 FFT pipeline, placed directly downstream of the last butterfly stage and its delay lines. The pipeline emits each N-point frame in bit-reversed index order; this block buffers frames in a ping-pong memory and re-emits every frame in natural order (X[0] … X[N-1]) as a continuous stream. It sustains one sample per clock with no backpressure.

## Interface

Parameters:
- `width`, 16: bits per real and per imaginary component (two's complement, passed through unmodified).
- `log2n`, 3: log2 of the frame length N; N = 2**log2n; valid range 1..12.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input sample present this cycle.
- `in_re`  in  width  real part, bit-reversed frame order.
- `in_im`  in  width  imaginary part.
- `out_valid`  out  1  output sample present.
- `out_re`  out  width  real part, natural order.
- `out_im`  out  width  imaginary part.
- `out_last`  out  1  high with the sample at natural index N-1.
- `out_idx`  out  log2n  natural index of the current output sample.

## Operation

- Memory: two banks of N entries, each 2*width bits.
- Write side:
  - `wr_cnt` (log2n bits) counts accepted samples.
  - On `in_valid`, the sample is written to bank `wr_bank` at address bitrev(`wr_cnt`), where bit k maps to bit log2n-1-k.
  - If `wr_cnt` = N-1: `wr_cnt` wraps to 0, `wr_bank` toggles, and bank `wr_bank` is marked full.
  - Cycles with `in_valid` low hold all write state.
- Read FSM:
  - Two states, IDLE and READ. `rd_cnt` is log2n bits.
  - IDLE: when any bank is full, go to READ with `rd_bank` set to that bank and `rd_cnt` = 0. The full flag clears when reading of that bank begins.
  - READ: each cycle, read address `rd_cnt` of `rd_bank`, then increment `rd_cnt`.
  - At `rd_cnt` = N-1: if the other bank is full at that edge, including a bank that becomes full in the same cycle, continue in READ on the other bank with `rd_cnt` = 0. Otherwise go to IDLE.
- Output register: `out_re`/`out_im`/`out_idx`/`out_last` register the read data and index; `out_valid` is high exactly one cycle after each READ-state read.
- Rate rule: input is at most one sample per cycle and the reader drains one per cycle, so a bank is always drained before the writer re-enters it. No overflow logic.
- Reset (any cycle, including mid-frame or mid-read): partial input frame discarded, both full flags cleared, `wr_cnt`=`rd_cnt`=0, `wr_bank`=`rd_bank`=0, FSM to IDLE. Memory contents are don't-care.
- Output reset values: `out_valid`=0, `out_re`=0, `out_im`=0, `out_last`=0, `out_idx`=0.

## Timing

- Let cycle t be the rising edge that accepts the last sample of a frame.
- The FSM is in READ from edge t+1. The first output (index 0) is valid after edge t+2.
- Latency from last input to first output is 2 cycles. Index N-1 appears after edge t+N+1.
- Back-to-back input frames produce a gapless output stream; `out_last` repeats every N cycles.
- Gaps in `in_valid` delay frame completion only. Output within a frame is always contiguous.

## Configuration

- `FFT_REORDER_SOP_EN` defined:
  - Adds input port `in_sop` (1 bit), sampled only while `in_valid` is high.
  - `in_valid`&&`in_sop` forces the sample to address bitrev(0) = 0 of the current `wr_bank` and sets `wr_cnt` to 1, discarding any partial frame in that bank.
  - If `in_sop` arrives at `wr_cnt` = 0, behaviour is identical to the non-SOP case.
- `FFT_REORDER_SOP_EN` undefined: no `in_sop` port. Framing is purely by counting valid samples from reset.

## Test plan

- N=8, reset, then one frame of 8 consecutive valid inputs with re = input position (0,4,2,6,1,5,3,7 arriving in that order as values 0..7 at positions bitrev) -> `out_re` 0,1,…,7 starting 2 cycles after last input; `out_last` only on the 8th; `out_idx` 0..7.
- Three back-to-back frames at full rate -> 24 consecutive `out_valid` cycles with no gap; `out_last` every 8th cycle; frame data not mixed.
- `in_valid` toggling 1,0,1,0 through a frame -> identical output values to the full-rate frame; output contiguous, first output 2 cycles after the 8th valid.
- `rst` asserted for 1 cycle after 5 samples of a frame, then a full frame -> all outputs 0 and `out_valid`=0 during reset; only the new frame is emitted; the 5 stale samples never appear.
- `rst` asserted mid-read (at `out_idx`=3) -> `out_valid` low after that edge; the next full frame is emitted correctly from index 0.
- With `FFT_REORDER_SOP_EN`: 3 samples, then `in_sop` plus 8 samples -> exactly one output frame, matching the 8 samples after the SOP.
